spi_master_arbiter: RTL and testbench

Shares one spi_master instance between N_CLIENTS requesters, each owning one chip select. Grants are round-robin. The block frames each granted transaction with a chip-select setup time, then the spi_master wr_req/rd_req/ack handshake, then a chip-select hold time and an inter-transaction gap. It sits between client logic (register banks, ADC/DAC sequencers) and spi_master. The spi_master timing inputs (n*_mosi, n*_sclk, n*_miso, nb_*) are wired straight through and are not touched by this block.

---
 rtl/spi_master_arbiter_pkg.sv | 19 +
 rtl/spi_master_arbiter_rr_arbiter.sv | 40 ++++
 rtl/spi_master_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_arbiter_pkg.sv
// rtl/spi_master_arbiter_pkg.sv - state encoding and constant helpers for the SPI master arbiter
package spi_master_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    XFER    = 3'd2,
    RELEASE = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// rtl/spi_master_arbiter_rr_arbiter.sv - round-robin pointer with find-first search starting after the last grant
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx;

  // Walk from the farthest slot back to last+1 so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last_q) + i) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    last_d = (advance && grant_valid) ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - shares one spi_master between N clients with chip-select setup/hold/gap framing
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int DW        = 32,
  parameter int CS_SETUP  = 4,
  parameter int CS_HOLD   = 4,
  parameter int CS_GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CLIENTS-1:0]  c_wr_req,
  input  logic [N_CLIENTS-1:0]  c_rd_req,
  input  logic [N_CLIENTS*DW-1:0] c_wr_data,
  output logic [N_CLIENTS-1:0]  c_ack,
  output logic [DW-1:0]         c_rd_data,
  output logic                  m_wr_req,
  output logic                  m_rd_req,
  output logic [DW-1:0]         m_wr_data,
  input  logic [DW-1:0]         m_rd_data,
  input  logic                  m_ack,
  output logic [N_CLIENTS-1:0]  cs_n,
  output logic                  busy
);

  localparam int IW = $clog2(N_CLIENTS);
  localparam int CW = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [CW-1:0] HOLD_LD  = CW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
  localparam logic [CW-1:0] GAP_LD   = CW'(CS_GAP - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          g_q, g_d;
  logic                   op_wr_q, op_wr_d, op_rd_q, op_rd_d;
  logic [N_CLIENTS-1:0]   cs_n_q, cs_n_d;
  logic                   m_wr_req_q, m_wr_req_d, m_rd_req_q, m_rd_req_d;
  logic [DW-1:0]          m_wr_data_q, m_wr_data_d;
  logic [N_CLIENTS-1:0]   c_ack_q, c_ack_d;
  logic [DW-1:0]          c_rd_data_q, c_rd_data_d;

  logic                   advance, grant_valid;
  logic [IW-1:0]          grant_idx;
  logic [DW-1:0]          wr_data_arr [N_CLIENTS];

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_slice
    assign wr_data_arr[i] = c_wr_data[i*DW +: DW];
  end

  rr_arbiter #(.N(N_CLIENTS)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (c_wr_req | c_rd_req),
    .advance     (advance),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    g_d         = g_q;
    op_wr_d     = op_wr_q;
    op_rd_d     = op_rd_q;
    cs_n_d      = cs_n_q;
    m_wr_req_d  = m_wr_req_q;
    m_rd_req_d  = m_rd_req_q;
    m_wr_data_d = m_wr_data_q;
    c_ack_d     = c_ack_q;
    c_rd_data_d = c_rd_data_q;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          advance            = 1'b1;
          g_d                = grant_idx;
          op_wr_d            = c_wr_req[grant_idx];
          op_rd_d            = c_rd_req[grant_idx];
          m_wr_data_d        = wr_data_arr[grant_idx];
          cs_n_d             = '1;
          cs_n_d[grant_idx]  = 1'b0;
          if (CS_SETUP == 0) begin
            state_d    = XFER;
            m_wr_req_d = c_wr_req[grant_idx];
            m_rd_req_d = c_rd_req[grant_idx];
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d    = XFER;
          m_wr_req_d = op_wr_q;
          m_rd_req_d = op_rd_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      XFER: begin
        if (m_ack) begin
          m_wr_req_d   = 1'b0;
          m_rd_req_d   = 1'b0;
          c_rd_data_d  = m_rd_data;
          c_ack_d[g_q] = 1'b1;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        // Both sides must let go: the client its request, spi_master its ack.
        if (!c_wr_req[g_q] && !c_rd_req[g_q] && !m_ack) begin
          c_ack_d = '0;
          if (CS_HOLD == 0) begin
            cs_n_d  = '1;
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = '1;
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      g_q         <= '0;
      op_wr_q     <= 1'b0;
      op_rd_q     <= 1'b0;
      cs_n_q      <= '1;
      m_wr_req_q  <= 1'b0;
      m_rd_req_q  <= 1'b0;
      m_wr_data_q <= '0;
      c_ack_q     <= '0;
      c_rd_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      g_q         <= g_d;
      op_wr_q     <= op_wr_d;
      op_rd_q     <= op_rd_d;
      cs_n_q      <= cs_n_d;
      m_wr_req_q  <= m_wr_req_d;
      m_rd_req_q  <= m_rd_req_d;
      m_wr_data_q <= m_wr_data_d;
      c_ack_q     <= c_ack_d;
      c_rd_data_q <= c_rd_data_d;
    end
  end

  assign cs_n      = cs_n_q;
  assign m_wr_req  = m_wr_req_q;
  assign m_rd_req  = m_rd_req_q;
  assign m_wr_data = m_wr_data_q;
  assign c_ack     = c_ack_q;
  assign c_rd_data = c_rd_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - directed scoreboard bench for spi_master_arbiter
module tb_spi_master_arbiter;

  localparam int NC      = 4;
  localparam int DW      = 32;
  localparam int ACK_DLY = 20;
  localparam int BUDGET  = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default framing (setup 4, hold 4, gap 2)
  logic [NC-1:0]    c_wr_req, c_rd_req, c_ack, cs_n;
  logic [NC*DW-1:0] c_wr_data;
  logic [DW-1:0]    c_rd_data, m_wr_data;
  logic [DW-1:0]    m_rd_data = '0;
  logic             m_wr_req, m_rd_req, busy;
  logic             m_ack = 1'b0;

  spi_master_arbiter #(.N_CLIENTS(NC), .DW(DW), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(2)) dut (
    .clk(clk), .rst(rst), .c_wr_req(c_wr_req), .c_rd_req(c_rd_req), .c_wr_data(c_wr_data),
    .c_ack(c_ack), .c_rd_data(c_rd_data), .m_wr_req(m_wr_req), .m_rd_req(m_rd_req),
    .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_ack(m_ack), .cs_n(cs_n), .busy(busy)
  );

  // Instance B: zero setup and hold
  logic [NC-1:0]    c_wr_req_b, c_rd_req_b, c_ack_b, cs_n_b;
  logic [NC*DW-1:0] c_wr_data_b;
  logic [DW-1:0]    c_rd_data_b, m_wr_data_b;
  logic [DW-1:0]    m_rd_data_b = '0;
  logic             m_wr_req_b, m_rd_req_b, busy_b;
  logic             m_ack_b = 1'b0;

  spi_master_arbiter #(.N_CLIENTS(NC), .DW(DW), .CS_SETUP(0), .CS_HOLD(0), .CS_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .c_wr_req(c_wr_req_b), .c_rd_req(c_rd_req_b), .c_wr_data(c_wr_data_b),
    .c_ack(c_ack_b), .c_rd_data(c_rd_data_b), .m_wr_req(m_wr_req_b), .m_rd_req(m_rd_req_b),
    .m_wr_data(m_wr_data_b), .m_rd_data(m_rd_data_b), .m_ack(m_ack_b), .cs_n(cs_n_b), .busy(busy_b)
  );

  // Monitor and spi_master responder for instance A (monitor samples before the model updates)
  int onehot_viol = 0, hi_run = 0, min_gap = 1000, grant_n = 0, mcnt = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, mreq_cyc = 0, mack_cyc = 0, cack_rise_cyc = 0, cack_fall_cyc = 0;
  int grant_log [64];
  bit seen_low = 1'b0, prev_hi = 1'b1, prev_mreq = 1'b0, prev_ack = 1'b0;
  logic [DW-1:0] mreq_data = '0;
  logic [1:0]    mreq_ops = '0;

  always @(negedge clk) begin
    int gi;
    if ($countones(~cs_n) > 1) onehot_viol++;
    if (&cs_n) begin
      hi_run++;
      if (!prev_hi) cs_rise_cyc = cyc;
    end else begin
      if (hi_run != 0) begin
        if (seen_low && hi_run < min_gap) min_gap = hi_run;
        gi = 0;
        for (int i = NC - 1; i >= 0; i--) if (!cs_n[i]) gi = i;
        cs_fall_cyc = cyc;
        if (grant_n < 64) grant_log[grant_n] = gi;
        grant_n++;
      end
      hi_run   = 0;
      seen_low = 1'b1;
    end
    prev_hi = &cs_n;
    if ((m_wr_req | m_rd_req) && !prev_mreq) begin
      mreq_cyc  = cyc;
      mreq_data = m_wr_data;
      mreq_ops  = {m_wr_req, m_rd_req};
    end
    prev_mreq = m_wr_req | m_rd_req;
    if ((|c_ack) && !prev_ack) cack_rise_cyc = cyc;
    if (!(|c_ack) && prev_ack) cack_fall_cyc = cyc;
    prev_ack = |c_ack;
    if (rst) begin
      m_ack = 1'b0;
      mcnt  = 0;
    end else if (m_wr_req | m_rd_req) begin
      if (!m_ack) begin
        if (mcnt == ACK_DLY - 1) begin
          m_ack     = 1'b1;
          m_rd_data = m_wr_data;
          mack_cyc  = cyc;
        end else begin
          mcnt++;
        end
      end
    end else begin
      m_ack = 1'b0;
      mcnt  = 0;
    end
  end

  // Monitor and responder for instance B
  int cs_fall_b = 0, cs_rise_b = 0, mreq_b = 0, cack_fall_b = 0, mcnt_b = 0;
  bit prev_hi_b = 1'b1, prev_mreq_b = 1'b0, prev_ack_b = 1'b0;

  always @(negedge clk) begin
    if (!(&cs_n_b) && prev_hi_b) cs_fall_b = cyc;
    if ((&cs_n_b) && !prev_hi_b) cs_rise_b = cyc;
    prev_hi_b = &cs_n_b;
    if ((m_wr_req_b | m_rd_req_b) && !prev_mreq_b) mreq_b = cyc;
    prev_mreq_b = m_wr_req_b | m_rd_req_b;
    if (!(|c_ack_b) && prev_ack_b) cack_fall_b = cyc;
    prev_ack_b = |c_ack_b;
    if (!rst && (m_wr_req_b | m_rd_req_b)) begin
      if (!m_ack_b) begin
        if (mcnt_b == 4) begin
          m_ack_b     = 1'b1;
          m_rd_data_b = m_wr_data_b;
        end else begin
          mcnt_b++;
        end
      end
    end else begin
      m_ack_b = 1'b0;
      mcnt_b  = 0;
    end
  end

  typedef struct {
    int            client;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int client, input logic [DW-1:0] data);
    exp_t e;
    e.client = client;
    e.data   = data;
    sb.push_back(e);
  endtask

  // Wait for the next ack, compare it with the scoreboard head, then act as the client and release.
  task automatic serve();
    int n;
    exp_t e;
    logic [NC-1:0] exp_ack;
    n = 0;
    while (c_ack == '0 && n < BUDGET) begin
      step();
      n++;
    end
    chk("ack_seen", 64'(c_ack != '0), 64'(1));
    if (c_ack != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_ack observed=%0h expected=none", c_ack);
      end else begin
        e = sb.pop_front();
        exp_ack = '0;
        exp_ack[e.client] = 1'b1;
        chk("ack_client", 64'(c_ack), 64'(exp_ack));
        chk("rd_data", 64'(c_rd_data), 64'(e.data));
      end
      c_wr_req = c_wr_req & ~c_ack;
      c_rd_req = c_rd_req & ~c_ack;
      n = 0;
      while (c_ack != '0 && n < BUDGET) begin
        step();
        n++;
      end
      chk("ack_drop", 64'(c_ack), 64'(0));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < BUDGET) begin
      step();
      n++;
    end
    chk("idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int g0, n;
    c_wr_req = '0; c_rd_req = '0; c_wr_data = '0;
    c_wr_req_b = '0; c_rd_req_b = '0; c_wr_data_b = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_cs_n", 64'(cs_n), 64'(4'hf));
    chk("rst_mreq", 64'({m_wr_req, m_rd_req}), 64'(0));
    chk("rst_c_ack", 64'(c_ack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rd_data", 64'(c_rd_data), 64'(0));
    chk("rst_wr_data", 64'(m_wr_data), 64'(0));
    rst = 1'b0;
    step();

    // Single write from client 1
    g0 = grant_n;
    c_wr_data[1*DW +: DW] = 32'h00005aaa;
    c_wr_req[1] = 1'b1;
    push(1, 32'h00005aaa);
    serve();
    wait_idle();
    chk("t1_grant", 64'(grant_log[g0]), 64'(1));
    chk("t1_m_wr_data", 64'(mreq_data), 64'(32'h00005aaa));
    chk("t1_setup", 64'(mreq_cyc - cs_fall_cyc), 64'(4));
    chk("t1_ack_latency", 64'(cack_rise_cyc - mack_cyc), 64'(1));
    chk("t1_hold", 64'(cs_rise_cyc - cack_fall_cyc), 64'(4));

    // Full-duplex loopback on client 0
    c_wr_data[0 +: DW] = 32'h00005aaa;
    c_wr_req[0] = 1'b1;
    c_rd_req[0] = 1'b1;
    push(0, 32'h00005aaa);
    serve();
    wait_idle();
    chk("t2_ops", 64'(mreq_ops), 64'(2'b11));

    // Reset pointer, then all clients at once
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    g0 = grant_n;
    for (int i = 0; i < NC; i++) begin
      c_wr_data[i*DW +: DW] = 32'hc0de0000 + 32'(i);
      push(i, 32'hc0de0000 + 32'(i));
    end
    c_wr_req = '1;
    repeat (NC) serve();
    wait_idle();
    for (int k = 0; k < NC; k++) chk("t3_order", 64'(grant_log[g0 + k]), 64'(k));

    // Fairness: client 2 re-requests while client 3 waits
    g0 = grant_n;
    c_wr_req[2] = 1'b1;
    c_wr_req[3] = 1'b1;
    push(2, 32'hc0de0002);
    push(3, 32'hc0de0003);
    serve();
    c_wr_req[2] = 1'b1;
    push(2, 32'hc0de0002);
    serve();
    serve();
    wait_idle();
    chk("t4_first", 64'(grant_log[g0]), 64'(2));
    chk("t4_second", 64'(grant_log[g0 + 1]), 64'(3));
    chk("t4_third", 64'(grant_log[g0 + 2]), 64'(2));

    // Reset during XFER
    c_wr_req[2] = 1'b1;
    n = 0;
    while (!m_wr_req && n < BUDGET) begin
      step();
      n++;
    end
    chk("t5_in_xfer", 64'(m_wr_req), 64'(1));
    repeat (3) step();
    rst = 1'b1;
    c_wr_req = '0;
    step();
    chk("t5_cs_n", 64'(cs_n), 64'(4'hf));
    chk("t5_mreq", 64'({m_wr_req, m_rd_req}), 64'(0));
    chk("t5_c_ack", 64'(c_ack), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    sb.delete();
    step();
    g0 = grant_n;
    c_wr_req[0] = 1'b1;
    c_wr_req[3] = 1'b1;
    push(0, 32'hc0de0000);
    push(3, 32'hc0de0003);
    serve();
    serve();
    wait_idle();
    chk("t5_first", 64'(grant_log[g0]), 64'(0));
    chk("t5_second", 64'(grant_log[g0 + 1]), 64'(3));

    // Zero setup / zero hold instance
    c_wr_data_b[3*DW +: DW] = 32'h12345678;
    c_wr_req_b[3] = 1'b1;
    n = 0;
    while (c_ack_b == '0 && n < BUDGET) begin
      step();
      n++;
    end
    chk("t6_ack", 64'(c_ack_b), 64'(4'b1000));
    chk("t6_rd_data", 64'(c_rd_data_b), 64'(32'h12345678));
    c_wr_req_b = '0;
    n = 0;
    while (busy_b && n < BUDGET) begin
      step();
      n++;
    end
    chk("t6_idle", 64'(busy_b), 64'(0));
    chk("t6_setup0", 64'(mreq_b - cs_fall_b), 64'(0));
    chk("t6_hold0", 64'(cs_rise_b - cack_fall_b), 64'(0));

    chk("cs_onehot", 64'(onehot_viol), 64'(0));
    chk("cs_gap_min2", 64'(min_gap >= 2), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
